// File: rtl/epu_ctrl.sv
// Host-facing control block for the EPU accelerator: register file, launch/run FSM,
// completion tracking, run-cycle counter and level interrupt.
module epu_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [2:0]  req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        start_o,
    output logic [3:0]  mode_o,
    output logic [31:0] weight_w8_o,
    input  logic        finish_i,
    output logic        irq_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_STATUS = 3'd1;
    localparam logic [2:0] A_MODE   = 3'd2;
    localparam logic [2:0] A_W8     = 3'd3;
    localparam logic [2:0] A_IRQ_EN = 3'd4;
    localparam logic [2:0] A_CYCLES = 3'd5;

    state_t            r_state;
    logic              r_start;
    logic              r_done;
    logic [CNT_W-1:0]  r_cycles;
    logic [3:0]        r_mode;
    logic [31:0]       r_w8;
    logic              r_irq_en;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_rdata;

    logic              w_accept;
    logic              w_wr;
    logic              w_rd;
    logic              w_busy;
    logic              w_irq;
    logic              w_start;
    logic              w_clr_done;
    logic [31:0]       w_cycles32;
    logic [31:0]       w_rdata;

    // Only one read can be outstanding: the response cycle blocks new requests.
    assign req_ready_o = ~r_rsp_valid;
    assign w_accept    = req_valid_i & req_ready_o;
    assign w_wr        = w_accept & req_write_i;
    assign w_rd        = w_accept & ~req_write_i;

    assign w_busy      = (r_state != ST_IDLE);
    assign w_irq       = r_done & r_irq_en;
    assign w_start     = w_wr && (req_addr_i == A_CTRL) && req_wdata_i[0] && (r_state == ST_IDLE);
    assign w_clr_done  = w_wr && (req_addr_i == A_CTRL) && req_wdata_i[1];
    assign w_cycles32  = 32'(r_cycles);

    always_comb begin
        // NOTE: default assignment first so every path drives w_rdata and no latch is inferred.
        w_rdata = '0;
        case (req_addr_i)
            A_STATUS: w_rdata = {29'd0, w_irq, r_done, w_busy};
            A_MODE:   w_rdata = {28'd0, r_mode};
            A_W8:     w_rdata = r_w8;
            A_IRQ_EN: w_rdata = {31'd0, r_irq_en};
            A_CYCLES: w_rdata = w_cycles32;
            default:  w_rdata = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_start  <= 1'b0;
            r_done   <= 1'b0;
            r_cycles <= '0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_LAUNCH;
                        r_start <= 1'b1;
                    end
                end
                ST_LAUNCH: r_state <= ST_RUN;
                ST_RUN: begin
                    if (finish_i) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase

            // Completion wins over a coincident clear-done so a finished run is never lost.
            if ((r_state == ST_RUN) && finish_i) begin
                r_done <= 1'b1;
            end else if (w_start || w_clr_done) begin
                r_done <= 1'b0;
            end

            if (w_start || (r_state == ST_LAUNCH)) begin
                r_cycles <= '0;
            end else if ((r_state == ST_RUN) && (r_cycles != {CNT_W{1'b1}})) begin
                r_cycles <= r_cycles + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode      <= '0;
            r_w8        <= '0;
            r_irq_en    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= w_rd;
            if (w_rd) r_rsp_rdata <= w_rdata;

            // Operands are frozen while the accelerator is busy.
            if (w_wr && !w_busy && (req_addr_i == A_MODE)) r_mode <= req_wdata_i[3:0];
            if (w_wr && !w_busy && (req_addr_i == A_W8))   r_w8   <= req_wdata_i;
            if (w_wr && (req_addr_i == A_IRQ_EN))          r_irq_en <= req_wdata_i[0];
        end
    end

    assign start_o     = r_start;
    assign mode_o      = r_mode;
    assign weight_w8_o = r_w8;
    assign irq_o       = w_irq;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rsp_rdata;

endmodule

// File: tb/tb_epu_ctrl.sv
// Self-checking bench for epu_ctrl: read responses are scored against a queue of
// expected values; side-band outputs are checked directly after each clock edge.
module tb_epu_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [2:0]  req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        start_o;
    logic [3:0]  mode_o;
    logic [31:0] weight_w8_o;
    logic        finish_i;
    logic        irq_o;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] sb_q[$];

    epu_ctrl #(.CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_write_i (req_write_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .start_o     (start_o),
        .mode_o      (mode_o),
        .weight_w8_o (weight_w8_o),
        .finish_i    (finish_i),
        .irq_o       (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        check("ready_before_write", 32'(req_ready_o), 32'd1);
        req_valid_i = 1'b1;
        req_write_i = 1'b1;
        req_addr_i  = a;
        req_wdata_i = d;
        step();
        req_valid_i = 1'b0;
        req_write_i = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, input logic [31:0] exp);
        check("ready_before_read", 32'(req_ready_o), 32'd1);
        req_valid_i = 1'b1;
        req_write_i = 1'b0;
        req_addr_i  = a;
        sb_q.push_back(exp);
        step();
        req_valid_i = 1'b0;
        step();
    endtask

    // Response monitor: every rsp_valid_o pulse must match the oldest expected read.
    always @(negedge clk) begin
        if (!rst && rsp_valid_o) begin
            check("ready_low_during_rsp", 32'(req_ready_o), 32'd0);
            if (sb_q.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                check("rsp_rdata", rsp_rdata_o, sb_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        req_valid_i = 1'b0;
        req_write_i = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        finish_i    = 1'b0;
        repeat (3) step();

        check("rst_start", 32'(start_o), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_rsp_rdata", rsp_rdata_o, 32'd0);
        check("rst_ready", 32'(req_ready_o), 32'd1);
        check("rst_irq", 32'(irq_o), 32'd0);
        check("rst_mode", 32'(mode_o), 32'd0);
        check("rst_w8", weight_w8_o, 32'd0);
        rst = 1'b0;
        step();
        bus_read(3'd1, 32'h0);
        bus_read(3'd5, 32'h0);
        bus_read(3'd4, 32'h0);

        // Basic launch with operands, then busy status and frozen operands during RUN.
        bus_write(3'd2, 32'h5);
        bus_write(3'd3, 32'hDEADBEEF);
        check("mode_o_idle", 32'(mode_o), 32'h5);
        check("w8_o_idle", weight_w8_o, 32'hDEADBEEF);
        bus_write(3'd0, 32'h1);                   // LAUNCH cycle follows
        check("start_pulse", 32'(start_o), 32'd1);
        bus_read(3'd1, 32'h1);                    // accepted in LAUNCH, returns busy
        check("start_one_cycle", 32'(start_o), 32'd0);
        bus_write(3'd2, 32'h7);
        check("mode_frozen", 32'(mode_o), 32'h5);
        bus_write(3'd0, 32'h1);
        check("no_restart", 32'(start_o), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("no_restart_run", 32'(start_o), 32'd0);
        end
        finish_i = 1'b1;                          // 10th RUN cycle after start_o
        step();
        finish_i = 1'b0;
        check("w8_frozen", weight_w8_o, 32'hDEADBEEF);
        bus_read(3'd1, 32'h2);
        bus_read(3'd5, 32'd10);
        bus_read(3'd2, 32'h5);
        bus_read(3'd0, 32'h0);

        // Interrupt on completion; finish_i held through LAUNCH must not end the run early.
        bus_write(3'd0, 32'h2);
        check("irq_after_clear", 32'(irq_o), 32'd0);
        bus_write(3'd4, 32'h1);
        check("irq_en_no_done", 32'(irq_o), 32'd0);
        bus_write(3'd0, 32'h1);
        finish_i = 1'b1;
        step();                                   // LAUNCH -> RUN, finish ignored
        check("irq_not_in_launch", 32'(irq_o), 32'd0);
        step();                                   // RUN completes
        finish_i = 1'b0;
        check("irq_on_done", 32'(irq_o), 32'd1);
        bus_read(3'd5, 32'd1);
        bus_read(3'd1, 32'h6);
        bus_write(3'd0, 32'h2);
        check("irq_cleared", 32'(irq_o), 32'd0);
        bus_read(3'd1, 32'h0);

        // Start+clear in one write launches; clear-done coinciding with finish keeps done.
        bus_write(3'd0, 32'h3);
        check("start_with_clear", 32'(start_o), 32'd1);
        step();
        finish_i = 1'b1;
        bus_write(3'd0, 32'h2);
        finish_i = 1'b0;
        check("done_wins_irq", 32'(irq_o), 32'd1);
        bus_read(3'd1, 32'h6);
        bus_write(3'd4, 32'h0);
        check("irq_masked", 32'(irq_o), 32'd0);
        bus_read(3'd1, 32'h2);
        bus_read(3'd5, 32'd1);

        // Idle register access and the unused part of the map.
        bus_write(3'd2, 32'hFFFF_FFF9);
        bus_read(3'd2, 32'h9);
        bus_write(3'd3, 32'h1234_5678);
        bus_read(3'd3, 32'h1234_5678);
        bus_write(3'd6, 32'hFFFF_FFFF);
        bus_read(3'd6, 32'h0);
        bus_read(3'd7, 32'h0);
        bus_read(3'd4, 32'h0);

        // Reset in the middle of a run, then a stray finish.
        bus_write(3'd4, 32'h1);
        bus_write(3'd0, 32'h1);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_start", 32'(start_o), 32'd0);
        check("midrst_mode", 32'(mode_o), 32'd0);
        check("midrst_w8", weight_w8_o, 32'd0);
        finish_i = 1'b1;
        step();
        finish_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("midrst_no_start", 32'(start_o), 32'd0);
        end
        check("midrst_irq", 32'(irq_o), 32'd0);
        bus_read(3'd1, 32'h0);
        bus_read(3'd5, 32'h0);
        bus_read(3'd4, 32'h0);
        bus_read(3'd2, 32'h0);
        bus_read(3'd3, 32'h0);

        repeat (3) step();
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/epu_ctrl.md
EPU_CTRL -- requirements
Module: epu_ctrl

Interface
REQ-001 SHALL provide parameter CNT_W, default 32, width of run-cycle counter.
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port req_valid_i  input  1  host request valid.
REQ-005 SHALL provide port req_ready_o  output  1  request accepted when valid&ready.
REQ-006 SHALL provide port req_write_i  input  1  1=write, 0=read.
REQ-007 SHALL provide port req_addr_i  input  3  register word offset.
REQ-008 SHALL provide port req_wdata_i  input  32  write data.
REQ-009 SHALL provide port rsp_valid_o  output  1  read data valid, one-cycle pulse.
REQ-010 SHALL provide port rsp_rdata_o  output  32  read data.
REQ-011 SHALL provide port start_o  output  1  one-cycle launch pulse to accelerator.
REQ-012 SHALL provide port mode_o  output  4  layer mode to accelerator.
REQ-013 SHALL provide port weight_w8_o  output  32  w8 operand to accelerator.
REQ-014 SHALL provide port finish_i  input  1  accelerator completion (pulse or level).
REQ-015 SHALL provide port irq_o  output  1  level interrupt, done & irq_en.

Function
REQ-016 SHALL decode register map: 0 CTRL (W: bit0 start, bit1 clear-done; R: 0), 1 STATUS (R: bit0 busy, bit1 done, bit2 irq_o), 2 MODE[3:0] (R/W), 3 W8 (R/W), 4 IRQ_EN bit0 (R/W), 5 CYCLES (R), 6-7 read 0, write ignored.
REQ-017 SHALL drive req_ready_o low only in the cycle rsp_valid_o is high (one outstanding read); otherwise high.
REQ-018 SHALL return read data with rsp_valid_o=1 exactly one cycle after read acceptance; unused bits read 0; writes produce no response.
REQ-019 SHALL implement FSM states IDLE, LAUNCH, RUN.
REQ-020 SHALL move IDLE->LAUNCH on accepted CTRL write with bit0=1; start writes in LAUNCH/RUN ignored.
REQ-021 SHALL assert start_o for exactly the LAUNCH cycle, then move LAUNCH->RUN unconditionally.
REQ-022 SHALL ignore finish_i outside RUN; in RUN, first cycle finish_i=1 moves RUN->IDLE and sets done.
REQ-023 SHALL report busy=1 in LAUNCH and RUN.
REQ-024 SHALL ignore MODE and W8 writes while busy; mode_o/weight_w8_o reflect registers directly and stay stable during a run.
REQ-025 SHALL clear done on entering LAUNCH and on CTRL write bit1=1; when completion and clear-done coincide, done SHALL end set.
REQ-026 SHALL clear CYCLES in LAUNCH, increment once per RUN cycle including the finish cycle, saturate at 2^CNT_W-1, hold value in IDLE.
REQ-027 SHALL drive irq_o = done & irq_en combinationally from registers; clearing irq_en masks without clearing done.
REQ-028 SHALL accept a CTRL write with bit0=1 and bit1=1 in IDLE as a start (done cleared by launch).

Reset
REQ-029 SHALL, on rst=1 at a clock edge, force state IDLE, mode=0, w8=0, irq_en=0, done=0, CYCLES=0, start_o=0, rsp_valid_o=0, rsp_rdata_o=0, req_ready_o=1, irq_o=0.
REQ-030 SHALL honour reset mid-run: start_o never pulses afterward until a new start write, and finish_i arriving later sets nothing.

Verification
REQ-031 SHALL verify: write MODE=0x5, W8=0xDEADBEEF, CTRL=1 -> start_o high one cycle, mode_o=5, weight_w8_o=0xDEADBEEF, STATUS read=0x1.
REQ-032 SHALL verify: finish_i asserted 10 cycles after start_o -> STATUS=0x2, CYCLES=10 (RUN cycles including finish), busy=0.
REQ-033 SHALL verify: IRQ_EN=1 then completion -> irq_o=1; CTRL=0x2 -> irq_o=0, STATUS=0x0.
REQ-034 SHALL verify: MODE=7 and CTRL=1 written during RUN -> mode_o unchanged, no second start_o pulse.
REQ-035 SHALL verify: CTRL=0x2 written in the same cycle finish_i completes run -> done=1 afterward.
REQ-036 SHALL verify: rst asserted during RUN then finish_i pulsed -> STATUS=0x0, irq_o=0, all registers at reset values.
